lock_clear: RTL and testbench

LOCK_CLEAR -- requirements
Module: lock_clear

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/collide_check.sv | 31 +++
 rtl/lock_clear.sv | 146 ++++++++++++++
 tb/tb_lock_clear.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the lock/clear block.
// Holds the playfield dimensions, the packed playfield type and the
// lock/clear state encoding.
package tetris_pkg;

  localparam int ROWS     = 22;
  localparam int VIS_ROWS = 20;
  localparam int COLS     = 10;

  typedef logic [ROWS-1:0][COLS-1:0] playfield_t;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/collide_check.sv
// Combinational landing detector for the falling piece.
// Ports:
//   piece   - visible rows of the falling piece's occupancy map
//   stack   - visible rows of the settled stack
//   collide - high when the piece cannot drop by one row
module collide_check
  import tetris_pkg::*;
#(
  parameter int NROWS = VIS_ROWS,
  parameter int NCOLS = COLS
) (
  input  logic [NROWS-1:0][NCOLS-1:0] piece,
  input  logic [NROWS-1:0][NCOLS-1:0] stack,
  output logic                        collide
);

  // The top stack row can never be underneath a piece block.
  logic unused_top;
  assign unused_top = |stack[0];

  // Bottom row is the floor; otherwise look one row below each piece row.
  always_comb begin
    collide = |piece[NROWS-1];
    for (int r = 0; r < NROWS - 1; r++) begin
      if (|(piece[r] & stack[r+1])) begin
        collide = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_clear.sv
// Merges a landed piece into the settled stack and removes full rows.
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   piece_array    - falling piece occupancy map (rows >= 20 ignored)
//   lock_req       - pulse: merge the piece into the stack
//   new_game       - pulse: clear stack and counters (IDLE only)
//   stack_array    - registered settled-block map, hidden rows read 0
//   collide        - piece cannot move down one row
//   busy           - sequence in progress
//   done           - one-cycle end-of-sequence pulse
//   lines_cleared  - rows removed by the last sequence
//   total_lines    - saturating cumulative cleared-row count
//   game_over      - sticky, a merge left blocks in row 0
module lock_clear #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS-1:0][COLS-1:0] piece_array,
  input  logic                      lock_req,
  input  logic                      new_game,
  output logic [ROWS-1:0][COLS-1:0] stack_array,
  output logic                      collide,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                lines_cleared,
  output logic [9:0]                total_lines,
  output logic                      game_over
);

  import tetris_pkg::*;

  localparam logic [4:0] LAST_ROW = 5'(VIS_ROWS - 1);

  state_t                           state;
  state_t                           state_next;
  logic [VIS_ROWS-1:0][COLS-1:0]    stack_q;
  logic [VIS_ROWS-1:0][COLS-1:0]    piece_vis;
  logic [VIS_ROWS-1:0][COLS-1:0]    merged;
  logic [4:0]                       ptr;
  logic                             row_full;

  // Hidden spawn rows of the piece never reach the stack.
  logic unused_rows;
  assign unused_rows = |piece_array[ROWS-1:VIS_ROWS];

  assign piece_vis   = piece_array[VIS_ROWS-1:0];
  assign merged      = stack_q | piece_vis;
  assign row_full    = &stack_q[ptr];
  assign stack_array = {{((ROWS - VIS_ROWS) * COLS){1'b0}}, stack_q};

  collide_check #(
    .NROWS(VIS_ROWS),
    .NCOLS(COLS)
  ) u_collide (
    .piece  (piece_vis),
    .stack  (stack_q),
    .collide(collide)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // new_game has priority over lock_req; a finished game ignores locks.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (!new_game && lock_req && !game_over) begin
          state_next = MERGE;
        end
      end
      MERGE: state_next = SCAN;
      SCAN: begin
        if (row_full) begin
          state_next = SHIFT;
        end else if (ptr == 5'd0) begin
          state_next = DONE;
        end
      end
      SHIFT:   state_next = SCAN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rows are scanned bottom-up; after a shift the same row index is
  // rescanned because it now holds the row that was above it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_q       <= '0;
      ptr           <= LAST_ROW;
      lines_cleared <= 3'd0;
      total_lines   <= 10'd0;
      game_over     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_game) begin
            stack_q       <= '0;
            lines_cleared <= 3'd0;
            total_lines   <= 10'd0;
            game_over     <= 1'b0;
          end
        end
        MERGE: begin
          stack_q       <= merged;
          lines_cleared <= 3'd0;
          ptr           <= LAST_ROW;
          if (|merged[0]) begin
            game_over <= 1'b1;
          end
        end
        SCAN: begin
          if (!row_full && ptr != 5'd0) begin
            ptr <= ptr - 5'd1;
          end
        end
        SHIFT: begin
          for (int r = 1; r < VIS_ROWS; r++) begin
            if (5'(r) <= ptr) begin
              stack_q[r] <= stack_q[r-1];
            end
          end
          stack_q[0] <= '0;
          if (lines_cleared != 3'd7) begin
            lines_cleared <= lines_cleared + 3'd1;
          end
          if (total_lines != 10'd1023) begin
            total_lines <= total_lines + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_clear.sv
// Testbench for lock_clear: directed scenarios plus random pieces,
// checked against a row-compaction reference model.
module tb_lock_clear;
  import tetris_pkg::*;

  localparam int V = VIS_ROWS;
  localparam int C = COLS;

  logic       clk = 1'b0;
  logic       rst;
  playfield_t piece_array;
  logic       lock_req;
  logic       new_game;
  playfield_t stack_array;
  logic       collide;
  logic       busy;
  logic       done;
  logic [2:0] lines_cleared;
  logic [9:0] total_lines;
  logic       game_over;

  int n_checks = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  logic [C-1:0] m_stack [V];
  int           m_lines;
  int           m_total;
  logic         m_over;

  always #5 clk = ~clk;

  lock_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .piece_array  (piece_array),
    .lock_req     (lock_req),
    .new_game     (new_game),
    .stack_array  (stack_array),
    .collide      (collide),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .total_lines  (total_lines),
    .game_over    (game_over)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < V; r++) m_stack[r] = '0;
    m_lines = 0;
    m_total = 0;
    m_over  = 1'b0;
  endfunction

  function automatic logic [255:0] model_bits();
    logic [255:0] b = '0;
    for (int r = 0; r < V; r++) b[r*C +: C] = m_stack[r];
    return b;
  endfunction

  function automatic logic model_collide(input playfield_t p);
    logic c = |p[V-1];
    for (int r = 0; r < V - 1; r++) if (|(p[r] & m_stack[r+1])) c = 1'b1;
    return c;
  endfunction

  // Returns expected lock-to-done latency, or 0 when the lock is ignored.
  function automatic int model_lock(input playfield_t p);
    logic [C-1:0] merged [V];
    int dst = V - 1;
    int n   = 0;
    if (m_over) return 0;
    for (int r = 0; r < V; r++) merged[r] = m_stack[r] | p[r];
    if (merged[0] != '0) m_over = 1'b1;
    for (int r = 0; r < V; r++) m_stack[r] = '0;
    for (int r = V - 1; r >= 0; r--) begin
      if (merged[r] == {C{1'b1}}) n++;
      else begin
        m_stack[dst] = merged[r];
        dst--;
      end
    end
    m_lines = n;
    m_total = (m_total + n > 1023) ? 1023 : m_total + n;
    return 22 + 2 * n;
  endfunction

  task automatic applyStimulus(input playfield_t p, output logic coll, output int lat);
    @(negedge clk);
    piece_array = p;
    #1 coll = collide;
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic lockCheck(input string tag, input playfield_t p);
    logic ec, oc;
    int   el, ol;
    ec = model_collide(p);
    el = model_lock(p);
    applyStimulus(p, oc, ol);
    checkOutput({tag, "_collide"}, oc, ec);
    checkOutput({tag, "_latency"}, ol, el);
    checkOutput({tag, "_stack"}, stack_array, model_bits());
    checkOutput({tag, "_lines"}, lines_cleared, m_lines);
    checkOutput({tag, "_total"}, total_lines, m_total);
    checkOutput({tag, "_over"}, game_over, m_over);
  endtask

  task automatic newGame();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  initial begin
    playfield_t p;
    int         ol, d0, r;

    rst = 1'b0; lock_req = 1'b0; new_game = 1'b0; piece_array = '0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_stack", stack_array, '0);
    checkOutput("reset_lines", lines_cleared, 3'd0);
    checkOutput("reset_total", total_lines, 10'd0);
    checkOutput("reset_over", game_over, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();

    // O piece on the floor, no clears
    p = '0; p[18] = 10'h030; p[19] = 10'h030;
    lockCheck("o_piece", p);

    // single clear
    newGame();
    p = '0; p[19] = 10'h3CF;
    lockCheck("preset1", p);
    p = '0; p[16] = 10'h010; p[17] = 10'h010; p[18] = 10'h010; p[19] = 10'h030;
    lockCheck("one_clear", p);

    // tetris: four clears
    newGame();
    p = '0; for (int i = 16; i < 20; i++) p[i] = 10'h3EF;
    lockCheck("preset4", p);
    p = '0; for (int i = 16; i < 20; i++) p[i] = 10'h010;
    lockCheck("four_clear", p);

    // lock_req and new_game while busy are ignored
    newGame();
    p = '0; p[18] = 10'h201; p[19] = 10'h201;
    void'(model_lock(p));
    @(negedge clk); piece_array = p; lock_req = 1'b1;
    @(negedge clk); lock_req = 1'b0;
    checkOutput("busy_merge", busy, 1'b1);
    repeat (4) @(negedge clk);
    lock_req = 1'b1; new_game = 1'b1;
    @(negedge clk);
    lock_req = 1'b0; new_game = 1'b0;
    ol = 0;
    for (int cyc = 6; cyc <= 120; cyc++) begin
      if (done === 1'b1) begin
        ol = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("busy_ign_latency", ol, 22);
    checkOutput("busy_ign_stack", stack_array, model_bits());
    repeat (3) @(negedge clk);
    checkOutput("busy_ign_idle", busy, 1'b0);

    // new_game and lock_req together
    p = '0; p[19] = 10'h0F0;
    @(negedge clk); piece_array = p; new_game = 1'b1; lock_req = 1'b1;
    @(negedge clk); new_game = 1'b0; lock_req = 1'b0;
    model_clear();
    d0 = done_cnt;
    checkOutput("ng_lock_busy", busy, 1'b0);
    checkOutput("ng_lock_stack", stack_array, '0);
    repeat (30) @(negedge clk);
    checkOutput("ng_lock_nodone", done_cnt - d0, 0);

    // random pieces, some completing rows, some touching hidden rows
    for (int it = 0; it < 16; it++) begin
      p = '0;
      r = $urandom_range(2, 19);
      p[r] = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) p[r] = ~m_stack[r];
      p[r-1] = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) p[20] = 10'($urandom_range(0, 1023));
      lockCheck("random", p);
    end

    // game over and sticky lock rejection
    newGame();
    p = '0; for (int i = 1; i < 20; i++) p[i] = 10'h010;
    lockCheck("column", p);
    p = '0; p[0] = 10'h038; p[1] = 10'h010;
    lockCheck("t_top", p);
    @(negedge clk); lock_req = 1'b1;
    @(negedge clk); lock_req = 1'b0;
    checkOutput("over_nobusy", busy, 1'b0);
    checkOutput("over_stack", stack_array, model_bits());
    newGame();
    checkOutput("ng_clears_over", game_over, 1'b0);

    // async reset mid-sequence
    p = '0; p[18] = 10'h0F0; p[19] = 10'h3FF;
    lockCheck("pre_reset", p);
    p = '0; p[18] = 10'h003; p[17] = 10'h003;
    @(negedge clk); piece_array = p; lock_req = 1'b1;
    @(negedge clk); lock_req = 1'b0;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_stack", stack_array, '0);
    checkOutput("mid_rst_lines", lines_cleared, 3'd0);
    checkOutput("mid_rst_total", total_lines, 10'd0);
    @(negedge clk); rst = 1'b0;
    model_clear();
    repeat (25) @(negedge clk);
    checkOutput("mid_rst_nodone", done_cnt - d0, 0);
    p = '0; p[18] = 10'h030; p[19] = 10'h030;
    lockCheck("after_reset", p);

    // total_lines saturation
    newGame();
    p = '0; for (int i = 16; i < 20; i++) p[i] = 10'h3FF;
    for (int it = 0; it < 257; it++) lockCheck("saturate", p);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
